ex_muldiv: RTL and testbench

Iterative multiply/divide unit on the execute side of the decode/execute pipeline register. It consumes the opcode, aux field and both register operands (`os`, `ot`) that the DE register presents. It runs signed or unsigned 32×32 multiply or 32/32 divide over 32 iterations, holding the front of the pipeline with `stall` while it works. Results go to architectural HI/LO registers, which MFHI/MFLO read back through `mf_data`.

---
 rtl/ex_muldiv_if.sv | 23 ++
 rtl/ex_muldiv.sv | 208 ++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// Execute-side bundle between the DE pipeline register and the multiply/divide unit.
// The master side is the DE register/pipeline control; the slave side is ex_muldiv.
interface ex_muldiv_if;
    logic [5:0]  op_in;
    logic [10:0] aux_in;
    logic [31:0] os_in;
    logic [31:0] ot_in;
    logic        stall;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] mf_data;

    modport master (
        output op_in, aux_in, os_in, ot_in,
        input  stall, busy, hi_out, lo_out, mf_data
    );

    modport slave (
        input  op_in, aux_in, os_in, ot_in,
        output stall, busy, hi_out, lo_out, mf_data
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO and MFHI/MFLO readback.
// DIV/DIVU and the restoring divider exist only when MULDIV_DIV_EN is defined.
module ex_muldiv (
    input  logic       clk,
    input  logic       rstd,
    ex_muldiv_if.slave md
);
    localparam logic [5:0] OpSpecial = 6'b000000;
    localparam logic [5:0] FnMult    = 6'b011000;
    localparam logic [5:0] FnMultu   = 6'b011001;
    localparam logic [5:0] FnMfhi    = 6'b010000;
    localparam logic [5:0] FnMflo    = 6'b010010;
`ifdef MULDIV_DIV_EN
    localparam logic [5:0] FnDiv     = 6'b011010;
    localparam logic [5:0] FnDivu    = 6'b011011;
`endif

    typedef enum logic [1:0] {StIdle, StBusy, StFin} state_e;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    state_e      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opb_q, opb_d;
    logic        neg_q, neg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
`ifdef MULDIV_DIV_EN
    logic        is_div_q, is_div_d;
    logic        rem_neg_q, rem_neg_d;
    logic        div0_q, div0_d;
    logic [31:0] os_raw_q, os_raw_d;
`endif

    logic [5:0]  funct;
    logic        is_special;
    logic        dec_mult, dec_multu, dec_mfhi, dec_mflo;
    logic        start, dec_signed;
    logic [31:0] os_mag, ot_mag;
    logic        unused_aux;

    assign funct      = md.aux_in[5:0];
    assign is_special = (md.op_in == OpSpecial);
    assign unused_aux = ^md.aux_in[10:6];

    always_comb begin
        dec_mult  = is_special && (funct == FnMult);
        dec_multu = is_special && (funct == FnMultu);
        dec_mfhi  = is_special && (funct == FnMfhi);
        dec_mflo  = is_special && (funct == FnMflo);
    end

`ifdef MULDIV_DIV_EN
    logic dec_div, dec_divu;
    assign dec_div    = is_special && (funct == FnDiv);
    assign dec_divu   = is_special && (funct == FnDivu);
    assign start      = dec_mult | dec_multu | dec_div | dec_divu;
    assign dec_signed = dec_mult | dec_div;
`else
    assign start      = dec_mult | dec_multu;
    assign dec_signed = dec_mult;
`endif

    // Signed ops iterate on magnitudes; signs are restored in StFin.
    assign os_mag = dec_signed ? abs32(md.os_in) : md.os_in;
    assign ot_mag = dec_signed ? abs32(md.ot_in) : md.ot_in;

    // Shift-add step: acc = {partial product, remaining multiplier bits}.
    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        mul_step = {mul_sum, acc_q[31:1]};
    end

`ifdef MULDIV_DIV_EN
    // Restoring step: acc = {partial remainder, dividend/quotient shift register}.
    logic [32:0] div_trial, div_diff;
    logic [63:0] div_step;
    always_comb begin
        div_trial = {acc_q[63:32], acc_q[31]};
        div_diff  = div_trial - {1'b0, opb_q};
        if (!div_diff[32]) begin
            div_step = {div_diff[31:0], acc_q[30:0], 1'b1};
        end else begin
            div_step = {div_trial[31:0], acc_q[30:0], 1'b0};
        end
    end
`endif

    logic [63:0] acc_neg;
    assign acc_neg = 64'd0 - acc_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MULDIV_DIV_EN
        is_div_d  = is_div_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        os_raw_d  = os_raw_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StBusy;
                    count_d = 5'd0;
                    neg_d   = dec_signed & (md.os_in[31] ^ md.ot_in[31]);
                    acc_d   = {32'd0, ot_mag};
                    opb_d   = os_mag;
`ifdef MULDIV_DIV_EN
                    is_div_d  = dec_div | dec_divu;
                    rem_neg_d = dec_signed & md.os_in[31];
                    div0_d    = (md.ot_in == 32'd0);
                    os_raw_d  = md.os_in;
                    if (dec_div | dec_divu) begin
                        acc_d = {32'd0, os_mag};
                        opb_d = ot_mag;
                    end
`endif
                end
            end
            StBusy: begin
                acc_d = mul_step;
`ifdef MULDIV_DIV_EN
                if (is_div_q) begin
                    acc_d = div_step;
                end
`endif
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                {hi_d, lo_d} = neg_q ? acc_neg : acc_q;
`ifdef MULDIV_DIV_EN
                if (is_div_q) begin
                    if (div0_q) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = os_raw_q;
                    end else begin
                        lo_d = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
                        hi_d = rem_neg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
                    end
                end
`endif
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_q <= StIdle;
            count_q <= 5'd0;
            acc_q   <= 64'd0;
            opb_q   <= 32'd0;
            neg_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
`ifdef MULDIV_DIV_EN
            is_div_q  <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            os_raw_q  <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MULDIV_DIV_EN
            is_div_q  <= is_div_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            os_raw_q  <= os_raw_d;
`endif
        end
    end

    // Stall is combinational in the start cycle so DE holds the op from its first cycle.
    assign md.stall  = ((state_q == StIdle) && start) || (state_q == StBusy);
    assign md.busy   = (state_q == StBusy);
    assign md.hi_out = hi_q;
    assign md.lo_out = lo_q;

    always_comb begin
        md.mf_data = 32'd0;
        if (dec_mfhi) begin
            md.mf_data = hi_q;
        end else if (dec_mflo) begin
            md.mf_data = lo_q;
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv; divide checks are built when MULDIV_DIV_EN is set.
module tb_ex_muldiv;
    localparam logic [5:0] OpSpecial = 6'b000000;
    localparam logic [5:0] OpBubble  = 6'b110111;
    localparam logic [5:0] FnMult    = 6'b011000;
    localparam logic [5:0] FnMultu   = 6'b011001;
    localparam logic [5:0] FnDiv     = 6'b011010;
    localparam logic [5:0] FnDivu    = 6'b011011;
    localparam logic [5:0] FnMfhi    = 6'b010000;
    localparam logic [5:0] FnMflo    = 6'b010010;

    logic clk = 1'b0;
    logic rstd;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc;

    ex_muldiv_if bus ();

    ex_muldiv dut (
        .clk  (clk),
        .rstd (rstd),
        .md   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
        bus.op_in  = op;
        bus.aux_in = {5'd0, fn};
        bus.os_in  = a;
        bus.ot_in  = b;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Counts stalled cycles; returns inside the first cycle with stall low.
    task automatic wait_stall(output int n);
        n = 0;
        #1;
        while (bus.stall === 1'b1 && n < 64) begin
            n++;
            step();
        end
    endtask

    initial begin
        rstd = 1'b0;
        drive(OpBubble, 6'd0, 32'd0, 32'd0);
        step();
        step();
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_hi", bus.hi_out, 32'd0);
        check("rst_lo", bus.lo_out, 32'd0);
        check("rst_mf", bus.mf_data, 32'd0);
        rstd = 1'b1;
        step();

        // MULTU max x max
        drive(OpSpecial, FnMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_stall(cyc);
        check("multu_stall_cycles", cyc, 32'd33);
        step();
        drive(OpSpecial, FnMflo, 32'd0, 32'd0);
        #1;
        check("multu_hi", bus.hi_out, 32'hFFFF_FFFE);
        check("multu_lo", bus.lo_out, 32'h0000_0001);
        check("mflo_data", bus.mf_data, 32'h0000_0001);
        check("mflo_nostall", {31'd0, bus.stall}, 32'd0);
        drive(OpSpecial, FnMfhi, 32'd0, 32'd0);
        #1;
        check("mfhi_data", bus.mf_data, 32'hFFFF_FFFE);
        drive(OpBubble, FnMfhi, 32'd0, 32'd0);
        #1;
        check("mf_bubble_zero", bus.mf_data, 32'd0);
        step();

        // MULT -7 x 3
        drive(OpSpecial, FnMult, 32'hFFFF_FFF9, 32'd3);
        wait_stall(cyc);
        check("mult_stall_cycles", cyc, 32'd33);
        step();
        drive(OpBubble, 6'd0, 32'd0, 32'd0);
        check("mult_hi", bus.hi_out, 32'hFFFF_FFFF);
        check("mult_lo", bus.lo_out, 32'hFFFF_FFEB);

        // Back-to-back MULTU 2x3 then 4x5
        drive(OpSpecial, FnMultu, 32'd2, 32'd3);
        wait_stall(cyc);
        check("b2b_first_cycles", cyc, 32'd33);
        step();
        drive(OpSpecial, FnMultu, 32'd4, 32'd5);
        #1;
        check("b2b_no_gap", {31'd0, bus.stall}, 32'd1);
        check("b2b_first_lo", bus.lo_out, 32'd6);
        check("b2b_first_hi", bus.hi_out, 32'd0);
        wait_stall(cyc);
        check("b2b_second_cycles", cyc, 32'd33);
        step();
        drive(OpBubble, FnMultu, 32'd9, 32'd9);
        #1;
        check("b2b_hi", bus.hi_out, 32'd0);
        check("b2b_lo", bus.lo_out, 32'd20);
        check("bubble_nostall", {31'd0, bus.stall}, 32'd0);
        step();
        check("bubble_nobusy", {31'd0, bus.busy}, 32'd0);
        check("bubble_lo_kept", bus.lo_out, 32'd20);

`ifndef MULDIV_DIV_EN
        drive(OpSpecial, FnDivu, 32'h1234_5678, 32'd0);
        #1;
        check("divu_off_nostall", {31'd0, bus.stall}, 32'd0);
        step();
        check("divu_off_nobusy", {31'd0, bus.busy}, 32'd0);
        step();
        check("divu_off_lo", bus.lo_out, 32'd20);
        check("divu_off_hi", bus.hi_out, 32'd0);
        drive(OpBubble, 6'd0, 32'd0, 32'd0);
        step();
`endif

        // Reset in the middle of a MULT
        drive(OpSpecial, FnMult, 32'd5, 32'd5);
        repeat (5) step();
        check("mid_busy", {31'd0, bus.busy}, 32'd1);
        check("mid_lo_stable", bus.lo_out, 32'd20);
        #2;
        rstd = 1'b0;
        drive(OpBubble, 6'd0, 32'd0, 32'd0);
        #1;
        check("mid_rst_stall", {31'd0, bus.stall}, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_hi", bus.hi_out, 32'd0);
        check("mid_rst_lo", bus.lo_out, 32'd0);
        step();
        rstd = 1'b1;
        repeat (40) step();
        check("post_rst_lo", bus.lo_out, 32'd0);
        check("post_rst_hi", bus.hi_out, 32'd0);
        check("post_rst_busy", {31'd0, bus.busy}, 32'd0);

`ifdef MULDIV_DIV_EN
        drive(OpSpecial, FnDiv, 32'hFFFF_FFF9, 32'd2);
        wait_stall(cyc);
        check("div_stall_cycles", cyc, 32'd33);
        step();
        drive(OpBubble, 6'd0, 32'd0, 32'd0);
        check("div_lo", bus.lo_out, 32'hFFFF_FFFD);
        check("div_hi", bus.hi_out, 32'hFFFF_FFFF);

        drive(OpSpecial, FnDiv, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_stall(cyc);
        step();
        drive(OpBubble, 6'd0, 32'd0, 32'd0);
        check("div_ovf_lo", bus.lo_out, 32'h8000_0000);
        check("div_ovf_hi", bus.hi_out, 32'd0);

        drive(OpSpecial, FnDivu, 32'd100, 32'd7);
        wait_stall(cyc);
        step();
        drive(OpBubble, 6'd0, 32'd0, 32'd0);
        check("divu_lo", bus.lo_out, 32'd14);
        check("divu_hi", bus.hi_out, 32'd2);

        drive(OpSpecial, FnDivu, 32'h1234_5678, 32'd0);
        wait_stall(cyc);
        check("div0_stall_cycles", cyc, 32'd33);
        step();
        drive(OpBubble, 6'd0, 32'd0, 32'd0);
        check("div0_lo", bus.lo_out, 32'hFFFF_FFFF);
        check("div0_hi", bus.hi_out, 32'h1234_5678);
`endif

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
